weight_loader: RTL and testbench

- Write-side counterpart to the per-neuron weight memories in a layer.
- Accepts a valid/ready stream of headers and weights, decodes the target layer and neuron, and drives the write port (address, data, one-hot enable) of the addressed neuron's weight memory.
- Sits between the host/DMA weight stream and the layer's neurons; it is instantiated once per layer.

---
 rtl/nn_pkg.sv | 32 +++
 rtl/onehot_dec.sv | 23 ++
 rtl/weight_loader.sv | 121 ++++++++++++
 tb/tb_weight_loader.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/nn_pkg.sv
// Shared header field layout, FSM encoding and sizing helper for the
// weight-loading path.
package nn_pkg;

    localparam int unsigned LAYER_MSB  = 15;
    localparam int unsigned LAYER_LSB  = 8;
    localparam int unsigned NEURON_MSB = 7;
    localparam int unsigned NEURON_LSB = 0;

    localparam int unsigned LAYER_W = LAYER_MSB - LAYER_LSB + 1;
    localparam int unsigned IDX_W   = NEURON_MSB - NEURON_LSB + 1;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StLoad = 2'd1,
        StSkip = 2'd2,
        StDone = 2'd3
    } state_e;

    // Bits needed to hold values 0..v-1 (0 for v<=1).
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/onehot_dec.sv
// Binary index to one-hot decoder with enable; all-zero when disabled or
// when the index is out of range.
module onehot_dec
    import nn_pkg::*;
#(
    parameter int unsigned num_out   = 5,
    parameter int unsigned idx_width = IDX_W
) (
    input  logic [idx_width-1:0] idx,
    input  logic                 en,
    output logic [num_out-1:0]   onehot
);

    always_comb begin
        onehot = '0;
        for (int i = 0; i < num_out; i++) begin
            if (en && (idx == idx_width'(i))) begin
                onehot[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/weight_loader.sv
// Decodes a header/weight stream and drives the write port of the addressed
// neuron's weight memory for one layer.
module weight_loader
    import nn_pkg::*;
#(
    parameter int unsigned num_weight    = 3,
    parameter int unsigned num_neuron    = 5,
    parameter int unsigned layer_no      = 1,
    parameter int unsigned address_width = 10,
    parameter int unsigned data_width    = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     s_valid,
    input  logic [data_width-1:0]    s_data,
    output logic                     s_ready,
    output logic [address_width-1:0] w_add,
    output logic [data_width-1:0]    w_in,
    output logic [num_neuron-1:0]    w_en,
    output logic                     blk_done,
    output logic                     all_loaded,
    output logic                     hdr_err
);

    localparam int unsigned cnt_width = (num_weight > 1) ? clog2(num_weight) : 1;
    localparam logic [cnt_width-1:0] last_cnt = cnt_width'(num_weight - 1);

    state_e                  state;
    logic [cnt_width-1:0]    wcnt;
    logic [IDX_W-1:0]        neuron;
    logic [num_neuron-1:0]   mask;
    logic [num_neuron-1:0]   dec_out;
    logic                    accept;
    logic                    wr_en;
    logic [LAYER_W-1:0]      hdr_layer;
    logic [IDX_W-1:0]        hdr_neuron;
    logic                    layer_ok;
    logic                    neuron_ok;

    assign accept     = s_valid && s_ready;
    assign wr_en      = accept && (state == StLoad);
    assign hdr_layer  = s_data[LAYER_MSB:LAYER_LSB];
    assign hdr_neuron = s_data[NEURON_MSB:NEURON_LSB];
    assign layer_ok   = (hdr_layer == LAYER_W'(layer_no));
    assign neuron_ok  = (32'(hdr_neuron) < num_neuron);

    onehot_dec #(
        .num_out  (num_neuron),
        .idx_width(IDX_W)
    ) u_dec (
        .idx   (neuron),
        .en    (wr_en),
        .onehot(dec_out)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= StIdle;
            wcnt       <= '0;
            neuron     <= '0;
            mask       <= '0;
            s_ready    <= 1'b0;
            w_add      <= '0;
            w_in       <= '0;
            w_en       <= '0;
            blk_done   <= 1'b0;
            all_loaded <= 1'b0;
            hdr_err    <= 1'b0;
        end else begin
            w_en     <= dec_out;
            blk_done <= 1'b0;
            s_ready  <= 1'b1;
            if (wr_en) begin
                w_add <= address_width'(wcnt);
                w_in  <= s_data;
            end
            unique case (state)
                StIdle: begin
                    if (accept) begin
                        wcnt <= '0;
                        if (layer_ok && neuron_ok) begin
                            neuron <= hdr_neuron;
                            state  <= StLoad;
                        end else begin
                            if (layer_ok) begin
                                hdr_err <= 1'b1;
                            end
                            state <= StSkip;
                        end
                    end
                end
                StLoad, StSkip: begin
                    if (accept) begin
                        if (wcnt == last_cnt) begin
                            wcnt <= '0;
                            if (state == StLoad) begin
                                // dec_out is the latched neuron's bit on this final write
                                state      <= StDone;
                                s_ready    <= 1'b0;
                                blk_done   <= 1'b1;
                                mask       <= mask | dec_out;
                                all_loaded <= &(mask | dec_out);
                            end else begin
                                state <= StIdle;
                            end
                        end else begin
                            wcnt <= wcnt + cnt_width'(1);
                        end
                    end
                end
                StDone: begin
                    state <= StIdle;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_weight_loader.sv
// Directed table plus corner-case sequences for weight_loader.
module tb_weight_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        s_valid;
    logic [15:0] s_data;
    logic        s_ready;
    logic [9:0]  w_add;
    logic [15:0] w_in;
    logic [4:0]  w_en;
    logic        blk_done;
    logic        all_loaded;
    logic        hdr_err;

    always #5 clk = ~clk;

    weight_loader #(
        .num_weight   (3),
        .num_neuron   (5),
        .layer_no     (1),
        .address_width(10),
        .data_width   (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .s_valid   (s_valid),
        .s_data    (s_data),
        .s_ready   (s_ready),
        .w_add     (w_add),
        .w_in      (w_in),
        .w_en      (w_en),
        .blk_done  (blk_done),
        .all_loaded(all_loaded),
        .hdr_err   (hdr_err)
    );

    typedef struct {
        logic        rst;
        logic        v;
        logic [15:0] d;
        logic        rdy;
        logic [4:0]  en;
        logic [9:0]  add;
        logic [15:0] win;
        logic        blk;
        logic        all;
        logic        err;
    } vec_t;

    vec_t tbl[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Apply inputs, clock once, sample 1ns after the edge.
    task automatic step(input logic r, input logic v, input logic [15:0] d);
        rst     = r;
        s_valid = v;
        s_data  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic addv(input logic r, input logic v, input logic [15:0] d, input logic rdy,
                        input logic [4:0] en, input logic [9:0] add, input logic [15:0] win,
                        input logic blk, input logic all, input logic err);
        vec_t t;
        t.rst = r; t.v = v; t.d = d; t.rdy = rdy; t.en = en; t.add = add; t.win = win;
        t.blk = blk; t.all = all; t.err = err;
        tbl.push_back(t);
    endtask

    task automatic block(input logic [15:0] hdr, input logic [4:0] en, input logic [15:0] w0,
                         input logic all_after);
        addv(0, 1, hdr,          1, 5'b0, 10'd0, 16'h0, 0, 0, 0);
        addv(0, 1, w0,           1, en,   10'd0, w0,    0, 0, 0);
        addv(0, 1, w0 + 16'd1,   1, en,   10'd1, w0 + 16'd1, 0, 0, 0);
        addv(0, 1, w0 + 16'd2,   0, en,   10'd2, w0 + 16'd2, 1, all_after, 0);
        addv(0, 0, 16'h0,        1, 5'b0, 10'd0, 16'h0, 0, all_after, 0);
    endtask

    initial begin
        logic [15:0] rd;
        logic        rv;
        int          cnt;
        int          cyc;

        rst = 1'b1; s_valid = 1'b0; s_data = '0;

        // Reset and first block with valid held high through DONE.
        addv(1, 0, 16'h0000, 0, 5'b0,     10'd0, 16'h0,    0, 0, 0);
        addv(1, 0, 16'h0000, 0, 5'b0,     10'd0, 16'h0,    0, 0, 0);
        addv(0, 0, 16'h0000, 1, 5'b0,     10'd0, 16'h0,    0, 0, 0);
        addv(0, 1, 16'h0102, 1, 5'b0,     10'd0, 16'h0,    0, 0, 0);
        addv(0, 1, 16'hAAAA, 1, 5'b00100, 10'd0, 16'hAAAA, 0, 0, 0);
        addv(0, 1, 16'hBBBB, 1, 5'b00100, 10'd1, 16'hBBBB, 0, 0, 0);
        addv(0, 1, 16'hCCCC, 0, 5'b00100, 10'd2, 16'hCCCC, 1, 0, 0);
        // Header held across DONE: refused there, accepted in the next IDLE.
        addv(0, 1, 16'h0100, 1, 5'b0,     10'd0, 16'h0,    0, 0, 0);
        addv(0, 1, 16'h0100, 1, 5'b0,     10'd0, 16'h0,    0, 0, 0);
        addv(0, 1, 16'h1111, 1, 5'b00001, 10'd0, 16'h1111, 0, 0, 0);
        addv(0, 1, 16'h2222, 1, 5'b00001, 10'd1, 16'h2222, 0, 0, 0);
        addv(0, 1, 16'h3333, 0, 5'b00001, 10'd2, 16'h3333, 1, 0, 0);
        addv(0, 0, 16'h0000, 1, 5'b0,     10'd0, 16'h0,    0, 0, 0);
        block(16'h0101, 5'b00010, 16'h0010, 0);
        block(16'h0103, 5'b01000, 16'h0030, 0);
        block(16'h0104, 5'b10000, 16'h0040, 1);
        // Layer mismatch: words swallowed, no flag.
        addv(0, 1, 16'h0302, 1, 5'b0,     10'd0, 16'h0,    0, 1, 0);
        addv(0, 1, 16'hDEAD, 1, 5'b0,     10'd0, 16'h0,    0, 1, 0);
        addv(0, 1, 16'hBEEF, 1, 5'b0,     10'd0, 16'h0,    0, 1, 0);
        addv(0, 1, 16'hF00D, 1, 5'b0,     10'd0, 16'h0,    0, 1, 0);
        // Reload of neuron 2 right after the skip.
        addv(0, 1, 16'h0102, 1, 5'b0,     10'd0, 16'h0,    0, 1, 0);
        addv(0, 1, 16'h5555, 1, 5'b00100, 10'd0, 16'h5555, 0, 1, 0);
        addv(0, 1, 16'h6666, 1, 5'b00100, 10'd1, 16'h6666, 0, 1, 0);
        addv(0, 1, 16'h7777, 0, 5'b00100, 10'd2, 16'h7777, 1, 1, 0);
        addv(0, 0, 16'h0000, 1, 5'b0,     10'd0, 16'h0,    0, 1, 0);
        // Out-of-range neuron in this layer: sticky error, no writes.
        addv(0, 1, 16'h0107, 1, 5'b0,     10'd0, 16'h0,    0, 1, 1);
        addv(0, 1, 16'h1234, 1, 5'b0,     10'd0, 16'h0,    0, 1, 1);
        addv(0, 1, 16'h2345, 1, 5'b0,     10'd0, 16'h0,    0, 1, 1);
        addv(0, 1, 16'h3456, 1, 5'b0,     10'd0, 16'h0,    0, 1, 1);
        addv(0, 0, 16'h0000, 1, 5'b0,     10'd0, 16'h0,    0, 1, 1);
        addv(1, 0, 16'h0000, 0, 5'b0,     10'd0, 16'h0,    0, 0, 0);
        addv(0, 0, 16'h0000, 1, 5'b0,     10'd0, 16'h0,    0, 0, 0);

        foreach (tbl[i]) begin
            step(tbl[i].rst, tbl[i].v, tbl[i].d);
            chk($sformatf("vec%0d rdy/en/blk/all/err", i),
                32'({s_ready, w_en, blk_done, all_loaded, hdr_err}),
                32'({tbl[i].rdy, tbl[i].en, tbl[i].blk, tbl[i].all, tbl[i].err}));
            if (tbl[i].en != 5'b0) begin
                chk($sformatf("vec%0d w_add", i), 32'(w_add), 32'(tbl[i].add));
                chk($sformatf("vec%0d w_in", i), 32'(w_in), 32'(tbl[i].win));
            end
        end

        // Gapped valid during LOAD: one write per accept, contiguous addresses.
        step(0, 1, 16'h0102);
        chk("gap hdr w_en", 32'(w_en), 32'h0);
        cnt = 0;
        cyc = 0;
        while (cnt < 3 && cyc < 60) begin
            rv = 1'($urandom_range(0, 1));
            rd = 16'($urandom);
            step(0, rv, rd);
            if (rv) begin
                chk("gap w_en", 32'(w_en), 32'h04);
                chk("gap w_add", 32'(w_add), 32'(cnt));
                chk("gap w_in", 32'(w_in), 32'(rd));
                cnt++;
                chk("gap blk_done", 32'(blk_done), 32'(cnt == 3));
            end else begin
                chk("gap idle w_en", 32'(w_en), 32'h0);
                chk("gap idle blk_done", 32'(blk_done), 32'h0);
            end
            cyc++;
        end
        chk("gap all words accepted", 32'(cnt), 32'd3);
        step(0, 0, 16'h0);
        chk("gap post blk/rdy", 32'({blk_done, s_ready}), 32'b01);

        // Reset after the second weight of a block, then a clean reload.
        step(0, 1, 16'h0103);
        step(0, 1, 16'h0A0A);
        chk("mid w_en0", 32'({w_en, w_add}), 32'({5'b01000, 10'd0}));
        step(0, 1, 16'h0B0B);
        chk("mid w_en1", 32'({w_en, w_add}), 32'({5'b01000, 10'd1}));
        step(1, 1, 16'h0C0C);
        chk("mid rst outs", 32'({s_ready, w_en, blk_done, all_loaded}), 32'h0);
        step(0, 0, 16'h0);
        chk("mid idle rdy/en", 32'({s_ready, w_en}), 32'({1'b1, 5'b0}));
        step(0, 1, 16'h0103);
        chk("mid hdr w_en", 32'(w_en), 32'h0);
        for (int k = 0; k < 3; k++) begin
            step(0, 1, 16'h0C00 + 16'(k));
            chk($sformatf("mid reload %0d", k), 32'({w_en, w_add, blk_done}),
                32'({5'b01000, 10'(k), k == 2}));
            chk($sformatf("mid reload w_in %0d", k), 32'(w_in), 32'(16'h0C00 + 16'(k)));
        end
        chk("mid all_loaded", 32'(all_loaded), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
